// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM states, forward selects and forwarding helper for the hazard controller
package hazard_pkg;
    typedef enum logic {RUN, MEM_WAIT} state_t;
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    // MEM result is younger than WB, so it wins when both write the same register
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic mem_we,
                                           input logic [4:0] mem_rd, input logic wb_we,
                                           input logic [4:0] wb_rd);
        return (mem_we && mem_rd != 5'd0 && mem_rd == rs) ? FWD_MEM :
               (wb_we && wb_rd != 5'd0 && wb_rd == rs) ? FWD_WB : FWD_NONE;
    endfunction
endpackage

// File: rtl/hazard_controller_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) count <= '0;
        else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush/forward control with memory wait FSM and watchdog
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_reg_write,
    input  logic             wb_reg_write,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             clear_if_id,
    output logic             clear_id_ex,
    output logic             clear_mem_wb,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             mem_start,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

    state_t          state, next_state;
    logic [WD_W-1:0] wd_cnt;
    logic            timeout_hit, mem_stall, branch_flush, load_use;

    // the cycle that completes MEM_TIMEOUT waits without mem_ready aborts the access
    assign timeout_hit = state == MEM_WAIT && !mem_ready && wd_cnt == WD_LAST;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= RUN;
        else state <= next_state;

    always_comb
        next_state = (state == RUN) ? (mem_req ? MEM_WAIT : RUN)
                                    : ((mem_ready || timeout_hit) ? RUN : MEM_WAIT);

    always_comb begin
        mem_stall    = (state == RUN) ? mem_req : (!mem_ready && !timeout_hit);
        branch_flush = !mem_stall && ex_branch_taken;
        load_use     = !mem_stall && !ex_branch_taken && ex_mem_read && ex_rd != 5'd0 &&
                       (ex_rd == id_rs1 || ex_rd == id_rs2);
        stall_pc     = mem_stall || load_use;
        stall_if_id  = mem_stall || load_use;
        stall_id_ex  = mem_stall;
        stall_ex_mem = mem_stall;
        clear_if_id  = branch_flush;
        clear_id_ex  = branch_flush || load_use;
        clear_mem_wb = mem_stall;
        mem_start    = reset && state == RUN && mem_req;
        forward_a    = fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
        forward_b    = fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wd_cnt      <= '0;
            mem_timeout <= 1'b0;
        end else begin
            wd_cnt <= (state == MEM_WAIT) ? wd_cnt + 1'b1 : '0;
            if (timeout_hit) mem_timeout <= 1'b1;
        end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .inc(stall_pc), .count(stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(clk), .reset(reset), .inc(branch_flush), .count(flush_events)
    );
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed checks of stall, flush, forwarding, memory FSM, watchdog and counters
module tb_hazard_controller;
    localparam int CNT_W = 4;
    localparam logic [6:0] IDLE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100010;
    localparam logic [6:0] FL   = 7'b0000110;
    localparam logic [6:0] MS   = 7'b1111001;

    logic clk = 0, reset = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rs1 = 0, ex_rs2 = 0, ex_rd = 0, mem_rd = 0, wb_rd = 0;
    logic ex_mem_read = 0, ex_branch_taken = 0, mem_reg_write = 0, wb_reg_write = 0;
    logic mem_req = 0, mem_ready = 0;
    logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, clear_if_id, clear_id_ex, clear_mem_wb;
    logic [1:0] forward_a, forward_b;
    logic mem_start, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_events;
    logic [6:0] ctl;
    int checks = 0, errors = 0;

    assign ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, clear_if_id, clear_id_ex, clear_mem_wb};

    hazard_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .mem_req(mem_req),
        .mem_ready(mem_ready), .stall_pc(stall_pc), .stall_if_id(stall_if_id),
        .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem), .clear_if_id(clear_if_id),
        .clear_id_ex(clear_id_ex), .clear_mem_wb(clear_mem_wb), .forward_a(forward_a),
        .forward_b(forward_b), .mem_start(mem_start), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        mem_req = 1;
        #1;
        chk("rst_mem_start", 32'(mem_start), 0);
        chk("rst_stall_cnt", 32'(stall_cycles), 0);
        chk("rst_flush_cnt", 32'(flush_events), 0);
        chk("rst_timeout", 32'(mem_timeout), 0);
        mem_req = 0;
        nxt(); reset = 1; #1;
        chk("idle_ctl", 32'(ctl), 32'(IDLE));
        // load-use on rs1
        nxt(); ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; #1;
        chk("lu_rs1_ctl", 32'(ctl), 32'(LU));
        nxt(); ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; #1;
        chk("lu_done_ctl", 32'(ctl), 32'(IDLE));
        chk("lu_stall_cnt", 32'(stall_cycles), 1);
        // load into x0 never stalls
        ex_mem_read = 1; #1;
        chk("lu_x0_ctl", 32'(ctl), 32'(IDLE));
        ex_rd = 9; id_rs2 = 9; #1;
        chk("lu_rs2_ctl", 32'(ctl), 32'(LU));
        // branch beats load-use
        nxt(); ex_rd = 5; id_rs1 = 5; id_rs2 = 0; ex_branch_taken = 1; #1;
        chk("br_lu_ctl", 32'(ctl), 32'(FL));
        nxt(); ex_branch_taken = 0; ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; #1;
        chk("br_flush_cnt", 32'(flush_events), 1);
        chk("br_stall_cnt", 32'(stall_cycles), 2);
        // forwarding
        mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1; ex_rs1 = 7; ex_rs2 = 3; #1;
        chk("fwd_a_mem", 32'(forward_a), 2);
        chk("fwd_b_none", 32'(forward_b), 0);
        mem_reg_write = 0; #1;
        chk("fwd_a_wb", 32'(forward_a), 1);
        mem_reg_write = 1; mem_rd = 3; ex_rs2 = 3; #1;
        chk("fwd_a_wb2", 32'(forward_a), 1);
        chk("fwd_b_mem", 32'(forward_b), 2);
        mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0; #1;
        chk("fwd_a_x0", 32'(forward_a), 0);
        chk("fwd_b_x0", 32'(forward_b), 0);
        mem_reg_write = 0; wb_reg_write = 0;
        // mem_ready in RUN is ignored
        mem_ready = 1; #1;
        chk("ready_run_ctl", 32'(ctl), 32'(IDLE));
        nxt(); mem_ready = 0; mem_req = 1; #1;
        chk("acc_start", 32'(mem_start), 1);
        chk("acc_c0_ctl", 32'(ctl), 32'(MS));
        nxt(); mem_req = 0; #1;
        chk("acc_c1_start", 32'(mem_start), 0);
        chk("acc_c1_ctl", 32'(ctl), 32'(MS));
        nxt(); ex_branch_taken = 1; #1;
        chk("acc_c2_br_ctl", 32'(ctl), 32'(MS));
        nxt(); ex_branch_taken = 0; #1;
        chk("acc_c3_ctl", 32'(ctl), 32'(MS));
        nxt(); mem_ready = 1; #1;
        chk("acc_c4_ready_ctl", 32'(ctl), 32'(IDLE));
        nxt(); mem_ready = 0; #1;
        chk("acc_back_run", 32'(ctl), 32'(IDLE));
        chk("acc_stall_cnt", 32'(stall_cycles), 6);
        chk("acc_flush_cnt", 32'(flush_events), 1);
        chk("acc_no_timeout", 32'(mem_timeout), 0);
        // watchdog
        mem_req = 1; #1;
        chk("wd_start", 32'(mem_start), 1);
        nxt(); mem_req = 0;
        for (int i = 1; i <= 3; i++) begin
            #1; chk($sformatf("wd_c%0d_ctl", i), 32'(ctl), 32'(MS));
            nxt();
        end
        #1;
        chk("wd_c4_ctl", 32'(ctl), 32'(IDLE));
        chk("wd_c4_flag", 32'(mem_timeout), 0);
        nxt(); #1;
        chk("wd_flag_set", 32'(mem_timeout), 1);
        chk("wd_run_ctl", 32'(ctl), 32'(IDLE));
        chk("wd_stall_cnt", 32'(stall_cycles), 10);
        nxt(); nxt(); #1;
        chk("wd_flag_sticky", 32'(mem_timeout), 1);
        // reset mid-access
        mem_req = 1; nxt(); #1;
        chk("rw_wait_ctl", 32'(ctl), 32'(MS));
        reset = 0; #1;
        chk("rw_rst_start", 32'(mem_start), 0);
        chk("rw_rst_stall", 32'(stall_cycles), 0);
        chk("rw_rst_flush", 32'(flush_events), 0);
        chk("rw_rst_flag", 32'(mem_timeout), 0);
        nxt(); reset = 1; #1;
        chk("rw_restart", 32'(mem_start), 1);
        nxt(); mem_req = 0; mem_ready = 1; #1;
        chk("rw_wait_start", 32'(mem_start), 0);
        chk("rw_ready_ctl", 32'(ctl), 32'(IDLE));
        chk("rw_stall_cnt", 32'(stall_cycles), 1);
        nxt(); mem_ready = 0;
        // saturation
        ex_mem_read = 1; ex_rd = 4; id_rs1 = 4;
        repeat (20) nxt();
        ex_mem_read = 0; #1;
        chk("sat_stall", 32'(stall_cycles), 15);
        ex_branch_taken = 1;
        repeat (20) nxt();
        ex_branch_taken = 0; #1;
        chk("sat_flush", 32'(flush_events), 15);
        chk("sat_stall_hold", 32'(stall_cycles), 15);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
